eth_tx_sched: RTL and testbench
===============================

# eth_tx_sched

Multi-target transmit scheduler for the Ethernet path. It sits between `eth_recv` (ARP results) and `eth_send` (packet generator). It keeps an ARP cache of `N_TGT` configured target IPs with periodic refresh, miss counting and expiry. On each idle slot of the sender it selects the next packet type and destination: ARP reply, ARP request, round-robin UDP, or none.

## Interface
Parameters:
- `CLK_HZ`, 100000000: clock frequency; the ms tick period is `CLK_HZ/1000` cycles.
- `N_TGT`, 2: number of target IPs (1..8).
- `ARP_PERIOD_MS`, 3000: ARP refresh period per target, in ms (1..65535).
- `ARP_MISS_MAX`, 3: consecutive unanswered requests before an entry becomes invalid (1..15).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `i_tgt_ip` in 32*N_TGT: target IPs, quasi-static. Target k occupies bits [32k+31:32k].
- `i_arp_op` in 2: one-cycle strobe from `eth_recv`. 1 = ARP request received, 2 = ARP response received, 0/3 = none.
- `i_arp_mac` in 48: sender MAC qualifying `i_arp_op`.
- `i_arp_ip` in 32: sender IP qualifying `i_arp_op`.
- `i_udp_req` in N_TGT: per-target UDP data ready (level).
- `i_tx_sop` in 1: start-of-packet from `eth_send`.
- `i_tx_eop` in 1: end-of-packet from `eth_send`.
- `o_pkt_type` out 4: packet type. 0 none, 1 ARP_REQ, 2 ARP_RESP, 3 UDP.
- `o_tgt_mac` out 48: destination MAC.
- `o_tgt_ip` out 32: destination IP.
- `o_tgt_idx` out max(1,clog2(N_TGT)): target index for ARP_REQ/UDP; 0 for ARP_RESP/none.
- `o_valid` out N_TGT: ARP cache entry valid mask.
- `o_ms_tick` out 1: one-cycle pulse each ms.

## Operation
- **ms tick:** a counter counts 0..CLK_HZ/1000-1. `o_ms_tick` pulses on wrap.
- **Per-target entry k** holds: `mac`, `valid`, `need`, `wait`, `miss` (4 bit), and a period counter (16 bit ms).
  - **Period expiry** (counter reaches ARP_PERIOD_MS-1 on a tick): counter reloads to 0 and `need` is set.
  - **Expiry with `wait`=1:** `miss` is incremented, saturating. When `miss` reaches ARP_MISS_MAX, `valid` is cleared.
  - **Response:** `i_arp_op`=2 with `i_arp_ip`==tgt_ip[k] loads `mac`, sets `valid`, and clears `wait` and `miss`. This takes priority over expiry in the same cycle.
  - **Request sent to k** (`i_tx_sop` while `o_pkt_type`=1 and `o_tgt_idx`=k): clears `need`, sets `wait`, and reloads the period counter.
- **Responder slot (single entry):**
  - `i_arp_op`=1 latches `i_arp_mac`/`i_arp_ip` and sets `resp_pend`. A newer request overwrites the pending one.
  - A sent ARP_RESP clears `resp_pend`, unless a new request arrives in the same cycle; in that case `resp_pend` stays set.
- **Sender state:** `idle` is set on `i_tx_eop` and cleared on `i_tx_sop`. If both occur in the same cycle, `eop` wins and `idle`=1.
- **Selection:** registered outputs update only while `idle`, and are frozen while busy. Priority order:
  1. `resp_pend` → ARP_RESP, with the latched MAC/IP.
  2. Lowest k with `need` → ARP_REQ, `o_tgt_ip`=tgt_ip[k]. `o_tgt_mac` = `mac[k]` if `valid[k]`, else FF:FF:FF:FF:FF:FF.
  3. Round robin from `rr_ptr` over k with `valid[k]` & `i_udp_req[k]` → UDP, with `mac[k]`/tgt_ip[k].
  4. Otherwise type 0; MAC/IP hold their last value.
- **Round-robin pointer:** `rr_ptr` advances to the sent index + 1, modulo N_TGT, on `i_tx_sop` while type=3.

## Timing
- **Reset values:**
  - Outputs: `o_pkt_type`=0, `o_tgt_mac`=FF..FF, `o_tgt_ip`=0, `o_tgt_idx`=0, `o_valid`=0, `o_ms_tick`=0.
  - Internal: all `need`=1, `wait`/`miss`/period counters 0, `resp_pend`=0, `idle`=1, `rr_ptr`=0.
- **First selection:** ARP_REQ for target 0 in the first cycle after reset release.
- **Latency:** 1 cycle from an input event (`i_arp_op`, `i_udp_req`, `i_tx_eop`) to the changed outputs.
- **Capture:** `eth_send` samples type/MAC/IP on the cycle it asserts `i_tx_sop`. Outputs are stable from then until the cycle after `i_tx_eop`.
- **Reset mid-packet:** all state returns to the reset values immediately, asynchronously. `eth_send` is reset by the same `rst_n`.
- **Ignored strobe:** `i_tx_sop` while `o_pkt_type`=0 updates `idle` only.

## Structure
- **Shared package `eth_pkg`:** `PKT_NONE`/`PKT_ARP_REQ`/`PKT_ARP_RESP`/`PKT_UDP` (4 bit), `ARP_OP_REQ`/`ARP_OP_RESP` (2 bit), and `MAC_BCAST`.
- **Sub-module `eth_arp_entry`:** one per target, generate-instantiated. It holds the per-entry state and period/miss logic. The top holds the tick, responder slot, arbiter and output registers.

## Test plan
- **Cold start:** N_TGT=2, no responses. Expect ARP_REQ idx0 with MAC FF..FF. After sop/eop, expect ARP_REQ idx1, then type 0.
- **Resolve:** response from 10.0.0.111 with MAC 00:11:22:33:44:55 while `i_udp_req`=2'b01. Expect `o_valid`=01 and UDP idx0 with that MAC one cycle later.
- **Round robin:** both entries valid, `i_udp_req`=11. Over 4 packets, expect idx sequence 0,1,0,1.
- **Priority:** ARP request from 10.0.0.5 arrives during a UDP packet. Expect ARP_RESP to 10.0.0.5 after eop, ahead of a pending ARP_REQ.
- **Expiry:** CLK_HZ=1000, ARP_PERIOD_MS=4, ARP_MISS_MAX=2, no answers. Expect `valid` cleared exactly at the 2nd unanswered expiry, and subsequent requests broadcast.
- **Simultaneous events:** response and expiry in the same cycle: expect `miss`=0 and `valid`=1. Reset asserted mid-packet: expect all reset values.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet path definitions: packet type codes, ARP opcodes, broadcast MAC.
package eth_pkg;

  typedef enum logic [3:0] {
    PKT_NONE     = 4'd0,
    PKT_ARP_REQ  = 4'd1,
    PKT_ARP_RESP = 4'd2,
    PKT_UDP      = 4'd3
  } pkt_type_e;

  localparam logic [1:0]  ARP_OP_REQ  = 2'd1;
  localparam logic [1:0]  ARP_OP_RESP = 2'd2;
  localparam logic [47:0] MAC_BCAST   = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/eth_arp_entry.sv
// One ARP cache entry: resolved MAC, refresh period counter, and miss/expiry tracking.
module eth_arp_entry
  import eth_pkg::*;
#(
  parameter int unsigned ARP_PERIOD_MS = 3000,
  parameter int unsigned ARP_MISS_MAX  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_i,
  input  logic [31:0] tgt_ip_i,
  input  logic [1:0]  arp_op_i,
  input  logic [47:0] arp_mac_i,
  input  logic [31:0] arp_ip_i,
  input  logic        req_sent_i,
  output logic        valid_o,
  output logic        valid_d_o,
  output logic        need_d_o,
  output logic [47:0] mac_d_o
);

  localparam logic [15:0] PER_LAST = 16'(ARP_PERIOD_MS - 1);
  localparam logic [3:0]  MISS_LIM = 4'(ARP_MISS_MAX);

  logic [47:0] mac_q, mac_d;
  logic        valid_q, valid_d, need_q, need_d, wait_q, wait_d;
  logic [3:0]  miss_q, miss_d;
  logic [15:0] per_q, per_d;

  always_comb begin
    mac_d   = mac_q;
    valid_d = valid_q;
    need_d  = need_q;
    wait_d  = wait_q;
    miss_d  = miss_q;
    per_d   = per_q;
    if (tick_i) begin
      if (per_q == PER_LAST) begin
        per_d  = '0;
        need_d = 1'b1;
        if (wait_q) begin
          if (miss_q != 4'hF) miss_d = miss_q + 4'd1;
          if (miss_d >= MISS_LIM) valid_d = 1'b0;
        end
      end else begin
        per_d = per_q + 16'd1;
      end
    end
    if (req_sent_i) begin
      need_d = 1'b0;
      wait_d = 1'b1;
      per_d  = '0;
    end
    // A matching response overrides any expiry outcome in the same cycle.
    if (arp_op_i == ARP_OP_RESP && arp_ip_i == tgt_ip_i) begin
      mac_d   = arp_mac_i;
      valid_d = 1'b1;
      wait_d  = 1'b0;
      miss_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_q   <= '0;
      valid_q <= 1'b0;
      need_q  <= 1'b1;
      wait_q  <= 1'b0;
      miss_q  <= '0;
      per_q   <= '0;
    end else begin
      mac_q   <= mac_d;
      valid_q <= valid_d;
      need_q  <= need_d;
      wait_q  <= wait_d;
      miss_q  <= miss_d;
      per_q   <= per_d;
    end
  end

  assign valid_o   = valid_q;
  assign valid_d_o = valid_d;
  assign need_d_o  = need_d;
  assign mac_d_o   = mac_d;

endmodule

// File: rtl/eth_tx_sched.sv
// Transmit scheduler: ms tick, ARP responder slot, per-target cache entries and the
// priority arbiter that picks the next packet for eth_send on each idle slot.
module eth_tx_sched
  import eth_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 100000000,
  parameter int unsigned N_TGT         = 2,
  parameter int unsigned ARP_PERIOD_MS = 3000,
  parameter int unsigned ARP_MISS_MAX  = 3,
  localparam int unsigned IW = (N_TGT > 1) ? $clog2(N_TGT) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [32*N_TGT-1:0]  i_tgt_ip,
  input  logic [1:0]           i_arp_op,
  input  logic [47:0]          i_arp_mac,
  input  logic [31:0]          i_arp_ip,
  input  logic [N_TGT-1:0]     i_udp_req,
  input  logic                 i_tx_sop,
  input  logic                 i_tx_eop,
  output logic [3:0]           o_pkt_type,
  output logic [47:0]          o_tgt_mac,
  output logic [31:0]          o_tgt_ip,
  output logic [IW-1:0]        o_tgt_idx,
  output logic [N_TGT-1:0]     o_valid,
  output logic                 o_ms_tick
);

  localparam int unsigned TICK_N = CLK_HZ / 1000;

  logic [31:0]   tick_cnt_q;
  logic          tick_q;
  pkt_type_e     type_q, type_d;
  logic [47:0]   mac_q, mac_d, rmac_q, rmac_d;
  logic [31:0]   ip_q, ip_d, rip_q, rip_d;
  logic [IW-1:0] idx_q, idx_d, rr_q, rr_d, ki, rk;
  logic          idle_q, idle_d, resp_pend_q, resp_pend_d, found;

  logic [N_TGT-1:0] req_sent, ent_valid_q, ent_valid_d, ent_need_d;
  logic [47:0]      ent_mac_d [N_TGT];
  logic [31:0]      tgt_ip_a  [N_TGT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else if (tick_cnt_q == 32'(TICK_N - 1)) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b1;
    end else begin
      tick_cnt_q <= tick_cnt_q + 32'd1;
      tick_q     <= 1'b0;
    end
  end

  for (genvar k = 0; k < N_TGT; k++) begin : g_ent
    assign tgt_ip_a[k] = i_tgt_ip[32*k +: 32];
    assign req_sent[k] = i_tx_sop && (type_q == PKT_ARP_REQ) && (idx_q == IW'(k));

    eth_arp_entry #(
      .ARP_PERIOD_MS(ARP_PERIOD_MS),
      .ARP_MISS_MAX (ARP_MISS_MAX)
    ) u_ent (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_i    (tick_q),
      .tgt_ip_i  (i_tgt_ip[32*k +: 32]),
      .arp_op_i  (i_arp_op),
      .arp_mac_i (i_arp_mac),
      .arp_ip_i  (i_arp_ip),
      .req_sent_i(req_sent[k]),
      .valid_o   (ent_valid_q[k]),
      .valid_d_o (ent_valid_d[k]),
      .need_d_o  (ent_need_d[k]),
      .mac_d_o   (ent_mac_d[k])
    );
  end

  always_comb begin
    idle_d = idle_q;
    if (i_tx_eop)      idle_d = 1'b1;
    else if (i_tx_sop) idle_d = 1'b0;
    resp_pend_d = resp_pend_q;
    rmac_d      = rmac_q;
    rip_d       = rip_q;
    if (i_tx_sop && type_q == PKT_ARP_RESP) resp_pend_d = 1'b0;
    if (i_arp_op == ARP_OP_REQ) begin
      resp_pend_d = 1'b1;
      rmac_d      = i_arp_mac;
      rip_d       = i_arp_ip;
    end
    rr_d = rr_q;
    if (i_tx_sop && type_q == PKT_UDP) rr_d = IW'((32'(idx_q) + 32'd1) % N_TGT);
  end

  // Arbiter works on next-state values so an input event shows up one cycle later.
  always_comb begin
    type_d = type_q;
    mac_d  = mac_q;
    ip_d   = ip_q;
    idx_d  = idx_q;
    found  = 1'b0;
    ki     = '0;
    rk     = '0;
    if (idle_d) begin
      type_d = PKT_NONE;
      idx_d  = '0;
      if (resp_pend_d) begin
        type_d = PKT_ARP_RESP;
        mac_d  = rmac_d;
        ip_d   = rip_d;
        found  = 1'b1;
      end
      for (int unsigned k = 0; k < N_TGT; k++) begin
        ki = IW'(k);
        if (!found && ent_need_d[ki]) begin
          type_d = PKT_ARP_REQ;
          idx_d  = ki;
          ip_d   = tgt_ip_a[ki];
          mac_d  = ent_valid_d[ki] ? ent_mac_d[ki] : MAC_BCAST;
          found  = 1'b1;
        end
      end
      for (int unsigned j = 0; j < N_TGT; j++) begin
        rk = IW'((32'(rr_d) + j) % N_TGT);
        if (!found && ent_valid_d[rk] && i_udp_req[rk]) begin
          type_d = PKT_UDP;
          idx_d  = rk;
          ip_d   = tgt_ip_a[rk];
          mac_d  = ent_mac_d[rk];
          found  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_q      <= PKT_NONE;
      mac_q       <= MAC_BCAST;
      ip_q        <= '0;
      idx_q       <= '0;
      rr_q        <= '0;
      idle_q      <= 1'b1;
      resp_pend_q <= 1'b0;
      rmac_q      <= '0;
      rip_q       <= '0;
    end else begin
      type_q      <= type_d;
      mac_q       <= mac_d;
      ip_q        <= ip_d;
      idx_q       <= idx_d;
      rr_q        <= rr_d;
      idle_q      <= idle_d;
      resp_pend_q <= resp_pend_d;
      rmac_q      <= rmac_d;
      rip_q       <= rip_d;
    end
  end

  assign o_pkt_type = type_q;
  assign o_tgt_mac  = mac_q;
  assign o_tgt_ip   = ip_q;
  assign o_tgt_idx  = idx_q;
  assign o_valid    = ent_valid_q;
  assign o_ms_tick  = tick_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Bench for eth_tx_sched: a two-target instance for selection/priority and a
// single-target fast-tick instance for refresh, miss and expiry behaviour.
module tb_eth_tx_sched;
  import eth_pkg::*;

  localparam logic [31:0] IP0 = 32'h0A00_006F;  // 10.0.0.111
  localparam logic [31:0] IP1 = 32'h0A00_0070;  // 10.0.0.112
  localparam logic [31:0] IP2 = 32'h0A00_00C8;  // 10.0.0.200
  localparam logic [31:0] IP5 = 32'h0A00_0005;
  localparam logic [31:0] IP6 = 32'h0A00_0006;
  localparam logic [31:0] IP7 = 32'h0A00_0007;
  localparam logic [47:0] MAC0 = 48'h0011_2233_4455;
  localparam logic [47:0] MAC1 = 48'h6677_8899_AABB;
  localparam logic [47:0] MACR5 = 48'hA0A1_A2A3_A4A5;
  localparam logic [47:0] MACR6 = 48'hB0B1_B2B3_B4B5;
  localparam logic [47:0] MACR7 = 48'hC0C1_C2C3_C4C5;
  localparam logic [47:0] MACT = 48'h0200_0000_00C8;
  localparam logic [47:0] MACT2 = 48'h0200_0000_00C9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst2_n;
  logic [63:0] tgt_ip;
  logic [1:0]  arp_op, arp_op2;
  logic [47:0] arp_mac, arp_mac2, o_mac, o_mac2;
  logic [31:0] arp_ip, arp_ip2, o_ip, o_ip2;
  logic [1:0]  udp_req, o_valid;
  logic [0:0]  udp_req2, o_valid2, o_idx, o_idx2;
  logic        sop, eop, sop2, eop2, o_tick, o_tick2;
  logic [3:0]  o_type, o_type2;

  eth_tx_sched #(.CLK_HZ(10000), .N_TGT(2), .ARP_PERIOD_MS(3000), .ARP_MISS_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n), .i_tgt_ip(tgt_ip), .i_arp_op(arp_op), .i_arp_mac(arp_mac),
    .i_arp_ip(arp_ip), .i_udp_req(udp_req), .i_tx_sop(sop), .i_tx_eop(eop),
    .o_pkt_type(o_type), .o_tgt_mac(o_mac), .o_tgt_ip(o_ip), .o_tgt_idx(o_idx),
    .o_valid(o_valid), .o_ms_tick(o_tick)
  );

  eth_tx_sched #(.CLK_HZ(1000), .N_TGT(1), .ARP_PERIOD_MS(4), .ARP_MISS_MAX(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .i_tgt_ip(IP2), .i_arp_op(arp_op2), .i_arp_mac(arp_mac2),
    .i_arp_ip(arp_ip2), .i_udp_req(udp_req2), .i_tx_sop(sop2), .i_tx_eop(eop2),
    .o_pkt_type(o_type2), .o_tgt_mac(o_mac2), .o_tgt_ip(o_ip2), .o_tgt_idx(o_idx2),
    .o_valid(o_valid2), .o_ms_tick(o_tick2)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  typedef struct {
    string       tag;
    logic [3:0]  typ;
    int          idx;
    logic [47:0] mac;
    logic [31:0] ip;
  } exp_t;
  exp_t sb[$];

  task automatic expect_sel(input string tag, input logic [3:0] t, input int idx,
                            input logic [47:0] mac, input logic [31:0] ip);
    exp_t e;
    e.tag = tag; e.typ = t; e.idx = idx; e.mac = mac; e.ip = ip;
    sb.push_back(e);
  endtask

  task automatic cmp_sel();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "_type"}, 64'(o_type), 64'(e.typ));
    chk({e.tag, "_idx"},  64'(o_idx),  64'(e.idx));
    chk({e.tag, "_mac"},  64'(o_mac),  64'(e.mac));
    chk({e.tag, "_ip"},   64'(o_ip),   64'(e.ip));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pkt();
    sop = 1'b1; cyc(); sop = 1'b0;
    eop = 1'b1; cyc(); eop = 1'b0;
  endtask

  task automatic pkt2();
    sop2 = 1'b1; eop2 = 1'b1; cyc(); sop2 = 1'b0; eop2 = 1'b0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_type"},  64'(o_type),  64'(PKT_NONE));
    chk({pfx, "_mac"},   64'(o_mac),   64'(MAC_BCAST));
    chk({pfx, "_ip"},    64'(o_ip),    64'd0);
    chk({pfx, "_idx"},   64'(o_idx),   64'd0);
    chk({pfx, "_valid"}, 64'(o_valid), 64'd0);
    chk({pfx, "_tick"},  64'(o_tick),  64'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nt;
    rst_n = 1'b0; rst2_n = 1'b0;
    tgt_ip = {IP1, IP0};
    arp_op = '0; arp_mac = '0; arp_ip = '0; udp_req = '0; sop = 1'b0; eop = 1'b0;
    arp_op2 = '0; arp_mac2 = '0; arp_ip2 = '0; udp_req2 = '0; sop2 = 1'b0; eop2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Cold start: two broadcast requests, then nothing to send
    expect_sel("cold_req0", PKT_ARP_REQ, 0, MAC_BCAST, IP0);
    cyc(); cmp_sel();
    sop = 1'b1;
    expect_sel("cold_busy", PKT_ARP_REQ, 0, MAC_BCAST, IP0);
    cyc(); sop = 1'b0; cmp_sel();
    eop = 1'b1;
    expect_sel("cold_req1", PKT_ARP_REQ, 1, MAC_BCAST, IP1);
    cyc(); eop = 1'b0; cmp_sel();
    expect_sel("cold_none", PKT_NONE, 0, MAC_BCAST, IP1);
    pkt(); cmp_sel();

    // Resolve target 0 with UDP pending on it
    udp_req = 2'b01; arp_op = ARP_OP_RESP; arp_mac = MAC0; arp_ip = IP0;
    expect_sel("resolve", PKT_UDP, 0, MAC0, IP0);
    cyc(); arp_op = '0; cmp_sel();
    chk("resolve_valid", 64'(o_valid), 64'h1);

    // Round robin across both resolved targets
    udp_req = 2'b11; arp_op = ARP_OP_RESP; arp_mac = MAC1; arp_ip = IP1;
    expect_sel("rr_start", PKT_UDP, 0, MAC0, IP0);
    cyc(); arp_op = '0; cmp_sel();
    chk("rr_valid", 64'(o_valid), 64'h3);
    for (int p = 0; p < 4; p++) begin
      sop = 1'b1;
      expect_sel("rr_busy", PKT_UDP, p % 2, (p % 2) ? MAC1 : MAC0, (p % 2) ? IP1 : IP0);
      cyc(); sop = 1'b0; cmp_sel();
      if (p == 3) begin
        arp_op = ARP_OP_REQ; arp_mac = MACR5; arp_ip = IP5;
      end
      cyc(); arp_op = '0;
      eop = 1'b1;
      if (p < 3)
        expect_sel("rr_next", PKT_UDP, (p + 1) % 2, ((p + 1) % 2) ? MAC1 : MAC0,
                   ((p + 1) % 2) ? IP1 : IP0);
      else
        expect_sel("prio_resp", PKT_ARP_RESP, 0, MACR5, IP5);
      cyc(); eop = 1'b0; cmp_sel();
    end

    // New request arriving as the pending reply is sent replaces it
    sop = 1'b1; arp_op = ARP_OP_REQ; arp_mac = MACR6; arp_ip = IP6;
    cyc(); sop = 1'b0; arp_op = '0;
    eop = 1'b1;
    expect_sel("resp_renew", PKT_ARP_RESP, 0, MACR6, IP6);
    cyc(); eop = 1'b0; cmp_sel();
    expect_sel("resp_done", PKT_UDP, 0, MAC0, IP0);
    pkt(); cmp_sel();

    // Reset in the middle of a UDP packet
    sop = 1'b1; cyc(); sop = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    arp_op = ARP_OP_REQ; arp_mac = MACR7; arp_ip = IP7;
    expect_sel("post_rst_resp", PKT_ARP_RESP, 0, MACR7, IP7);
    cyc(); arp_op = '0; cmp_sel();
    sop = 1'b1; eop = 1'b1;
    expect_sel("sop_eop_req0", PKT_ARP_REQ, 0, MAC_BCAST, IP0);
    cyc(); sop = 1'b0; eop = 1'b0; cmp_sel();

    nt = 0;
    repeat (100) begin
      cyc();
      if (o_tick) nt++;
    end
    chk("ms_tick_count", 64'(nt), 64'd10);

    // Fast-tick instance: refresh period 4 ms, invalid after 2 misses
    @(negedge clk);
    rst2_n = 1'b1;
    cyc();
    chk("x_first_type", 64'(o_type2), 64'(PKT_ARP_REQ));
    chk("x_first_mac", 64'(o_mac2), 64'(MAC_BCAST));
    pkt2();
    chk("x_sent_type", 64'(o_type2), 64'(PKT_NONE));
    arp_op2 = ARP_OP_RESP; arp_mac2 = MACT; arp_ip2 = IP2;
    cyc(); arp_op2 = '0;
    chk("x_resolved", 64'(o_valid2), 64'h1);
    repeat (2) cyc();
    chk("x_before_exp", 64'(o_type2), 64'(PKT_NONE));
    cyc();
    chk("x_refresh_type", 64'(o_type2), 64'(PKT_ARP_REQ));
    chk("x_refresh_mac", 64'(o_mac2), 64'(MACT));
    pkt2();
    repeat (4) cyc();
    chk("x_miss1_valid", 64'(o_valid2), 64'h1);
    repeat (3) cyc();
    chk("x_pre_miss2_valid", 64'(o_valid2), 64'h1);
    cyc();
    chk("x_miss2_valid", 64'(o_valid2), 64'h0);
    chk("x_miss2_type", 64'(o_type2), 64'(PKT_ARP_REQ));
    chk("x_miss2_mac", 64'(o_mac2), 64'(MAC_BCAST));
    pkt2();
    repeat (3) cyc();
    arp_op2 = ARP_OP_RESP; arp_mac2 = MACT2; arp_ip2 = IP2;
    cyc(); arp_op2 = '0;
    chk("x_simul_valid", 64'(o_valid2), 64'h1);
    chk("x_simul_mac", 64'(o_mac2), 64'(MACT2));
    pkt2();
    repeat (4) cyc();
    chk("x_miss_cleared", 64'(o_valid2), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
